// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline control block.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        HALTED  = 2'd2
    } pctrl_state_t;

    localparam int REG_W = 5;

    // Select code 0 means register file, k+1 means forwarding source k.
    function automatic int fwd_sel_width(input int nsrc);
        return (nsrc < 1) ? 1 : $clog2(nsrc + 1);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the datapath and latch/mux controls back to it.
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int NSRC  = 2,
    parameter int CNT_W = 16
);
    localparam int SW = fwd_sel_width(NSRC);

    logic                   ihit;
    logic                   dmem_req;
    logic                   dhit;
    logic [REG_W-1:0]       id_rs;
    logic [REG_W-1:0]       id_rt;
    logic [REG_W-1:0]       ex_rs;
    logic [REG_W-1:0]       ex_rt;
    logic [NSRC-1:0]        src_wen;
    logic [REG_W*NSRC-1:0]  src_wsel;
    logic [NSRC-1:0]        src_load;
    logic                   ex_mc_start;
    logic                   branch_taken;
    logic                   jump_dec;
    logic                   halt_mem;

    logic                   pc_en;
    logic                   fetch_en;
    logic                   dec_en;
    logic                   ex_en;
    logic                   mem_en;
    logic                   fetch_flush;
    logic                   dec_flush;
    logic                   ex_flush;
    logic [SW-1:0]          fwd_sel_a;
    logic [SW-1:0]          fwd_sel_b;
    logic                   halted;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       flush_cnt;

    modport master (
        output ihit, dmem_req, dhit, id_rs, id_rt, ex_rs, ex_rt,
               src_wen, src_wsel, src_load, ex_mc_start, branch_taken,
               jump_dec, halt_mem,
        input  pc_en, fetch_en, dec_en, ex_en, mem_en,
               fetch_flush, dec_flush, ex_flush,
               fwd_sel_a, fwd_sel_b, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dmem_req, dhit, id_rs, id_rt, ex_rs, ex_rt,
               src_wen, src_wsel, src_load, ex_mc_start, branch_taken,
               jump_dec, halt_mem,
        output pc_en, fetch_en, dec_en, ex_en, mem_en,
               fetch_flush, dec_flush, ex_flush,
               fwd_sel_a, fwd_sel_b, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_fwd_select.sv
// Priority match of one register against NSRC pending writes; youngest source wins.
module fwd_select
    import pipeline_ctrl_pkg::*;
#(
    parameter int NSRC = 2,
    parameter int SW   = fwd_sel_width(NSRC)
) (
    input  logic [REG_W-1:0]      match_reg,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [REG_W*NSRC-1:0] src_wsel,
    output logic [SW-1:0]         sel
);

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        sel = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (src_valid[k] && (src_wsel[k*REG_W +: REG_W] == match_reg) &&
                (match_reg != '0)) begin
                sel = SW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/forward controller for the pipelined MIPS core.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NSRC     = 2,
    parameter int LU_DEPTH = 1,
    parameter int MC_LAT   = 4,
    parameter int CNT_W    = 16
) (
    input logic           CLK,
    input logic           nRST,
    pipeline_ctrl_if.slave pif
);

    localparam int SW  = fwd_sel_width(NSRC);
    localparam int MCW = $clog2(MC_LAT);
    localparam logic [NSRC-1:0] LU_MASK = NSRC'((64'd1 << LU_DEPTH) - 64'd1);

    pctrl_state_t     state, state_nx;
    logic [MCW-1:0]   mc_cnt, mc_nx;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [SW-1:0]    sel_a, sel_b, lu_sel_rs, lu_sel_rt;
    logic [NSRC-1:0]  lu_valid;
    logic             ext_freeze, freeze, load_use, any_flush;
    logic             pc_en, fetch_en, dec_en, ex_en, mem_en;
    logic             fetch_flush, dec_flush, ex_flush;

    fwd_select #(.NSRC(NSRC), .SW(SW)) u_fwd_a (
        .match_reg(pif.ex_rs), .src_valid(pif.src_wen), .src_wsel(pif.src_wsel), .sel(sel_a));
    fwd_select #(.NSRC(NSRC), .SW(SW)) u_fwd_b (
        .match_reg(pif.ex_rt), .src_valid(pif.src_wen), .src_wsel(pif.src_wsel), .sel(sel_b));

    // Load-use reuses the same matcher, restricted to loads in the shallow sources.
    assign lu_valid = pif.src_load & pif.src_wen & LU_MASK;

    fwd_select #(.NSRC(NSRC), .SW(SW)) u_lu_rs (
        .match_reg(pif.id_rs), .src_valid(lu_valid), .src_wsel(pif.src_wsel), .sel(lu_sel_rs));
    fwd_select #(.NSRC(NSRC), .SW(SW)) u_lu_rt (
        .match_reg(pif.id_rt), .src_valid(lu_valid), .src_wsel(pif.src_wsel), .sel(lu_sel_rt));

    assign load_use   = (lu_sel_rs != '0) || (lu_sel_rt != '0);
    assign ext_freeze = !pif.ihit || (pif.dmem_req && !pif.dhit);
    assign freeze     = ext_freeze || (state != RUN);
    assign any_flush  = fetch_flush || dec_flush || ex_flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= RUN;
            mc_cnt <= '0;
        end else begin
            state  <= state_nx;
            mc_cnt <= mc_nx;
        end
    end

    // The start cycle is the first of MC_LAT execute cycles, so MC_BUSY lasts MC_LAT-1.
    always_comb begin
        state_nx = state;
        mc_nx    = mc_cnt;
        case (state)
            RUN: begin
                if (pif.halt_mem && !ext_freeze) begin
                    state_nx = HALTED;
                end else if (!freeze && pif.ex_mc_start && !pif.branch_taken) begin
                    state_nx = MC_BUSY;
                    mc_nx    = MCW'(MC_LAT - 1);
                end
            end
            MC_BUSY: begin
                if (pif.halt_mem && !ext_freeze) begin
                    state_nx = HALTED;
                    mc_nx    = '0;
                end else if (!ext_freeze) begin
                    if (mc_cnt == MCW'(1)) begin
                        state_nx = RUN;
                        mc_nx    = '0;
                    end else begin
                        mc_nx = mc_cnt - MCW'(1);
                    end
                end
            end
            HALTED: begin
                state_nx = HALTED;
            end
            default: begin
                state_nx = RUN;
                mc_nx    = '0;
            end
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        fetch_en    = 1'b0;
        dec_en      = 1'b0;
        ex_en       = 1'b0;
        mem_en      = 1'b0;
        fetch_flush = 1'b0;
        dec_flush   = 1'b0;
        ex_flush    = 1'b0;
        if (!freeze) begin
            ex_en  = 1'b1;
            mem_en = 1'b1;
            if (pif.branch_taken) begin
                pc_en       = 1'b1;
                fetch_en    = 1'b1;
                dec_en      = 1'b1;
                fetch_flush = 1'b1;
                dec_flush   = 1'b1;
                ex_flush    = 1'b1;
            end else if (load_use) begin
                dec_en    = 1'b1;
                dec_flush = 1'b1;
            end else begin
                pc_en       = 1'b1;
                fetch_en    = 1'b1;
                dec_en      = 1'b1;
                fetch_flush = pif.jump_dec;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (state != HALTED) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (any_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign pif.pc_en       = pc_en;
    assign pif.fetch_en    = fetch_en;
    assign pif.dec_en      = dec_en;
    assign pif.ex_en       = ex_en;
    assign pif.mem_en      = mem_en;
    assign pif.fetch_flush = fetch_flush;
    assign pif.dec_flush   = dec_flush;
    assign pif.ex_flush    = ex_flush;
    assign pif.fwd_sel_a   = sel_a;
    assign pif.fwd_sel_b   = sel_b;
    assign pif.halted      = (state == HALTED);
    assign pif.stall_cnt   = stall_cnt;
    assign pif.flush_cnt   = flush_cnt;

endmodule
